// File: rtl/fp_addsub_sched_pkg.sv
// Shared types and constants for the FP add/sub scheduler.
package fp_pkg;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_PACK,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                sign;
    logic [FP_EXP_W-1:0] exp;
    logic [FP_MAN_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_addsub_sched_arb.sv
// Round-robin arbiter: the search starts one past the last granted id.
module fp_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_id
);

  logic [IDW-1:0]  r_ptr;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_id;
  logic            w_hit;

  // pick the first requester after the pointer, wrapping around
  always_comb begin
    w_grant = '0;
    w_id    = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_hit && i_req[(int'(r_ptr) + k) % NREQ]) begin
        w_hit = 1'b1;
        w_id  = IDW'((int'(r_ptr) + k) % NREQ);
        w_grant[(int'(r_ptr) + k) % NREQ] = 1'b1;
      end
    end
  end

  assign o_grant = i_en ? w_grant : '0;
  assign o_id    = w_id;

  // pointer follows the granted id; reset value makes requester 0 win first
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_ptr <= IDW'(NREQ - 1);
    else if (i_en && w_hit) r_ptr <= w_id;
  end

endmodule

// File: rtl/fp_addsub_sched.sv
// Multi-cycle FP32 add/sub controller with round-robin request arbitration.
//
// state    | meaning
// S_IDLE   | waiting for a granted request; operands latched on accept
// S_UNPACK | split fields, order operands by exponent, detect specials
// S_ALIGN  | shift smaller mantissa right one bit per cycle
// S_ADD    | signed-magnitude add of aligned mantissas
// S_NORM   | one-bit-per-cycle normalize with underflow flush
// S_PACK   | truncate and assemble result, flag overflow/special
// S_DONE   | result presented until consumer accepts
module fp_addsub_sched
  import fp_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int MAX_ALIGN = 25
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  input  logic [NREQ-1:0]         req_sub,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [31:0]             res_data,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic                    res_ovf
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [7:0] MAX_D = 8'(MAX_ALIGN);

  state_t          r_state, w_state_nxt;
  fp32_t           r_a, r_b;
  logic            r_sub;
  logic [IDW-1:0]  r_id;
  logic            r_special;
  logic            r_sx, r_sy, r_sign;
  logic [23:0]     r_mx, r_my;
  logic [24:0]     r_man;
  logic [8:0]      r_exp;
  logic [7:0]      r_cnt;
  logic [31:0]     r_res_data;
  logic [IDW-1:0]  r_res_id;
  logic            r_res_ovf;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gid;
  logic            w_accept;
  logic            w_arb_en;
  logic [23:0]     w_ma, w_mb;
  logic            w_sb, w_special, w_b_big;
  logic [7:0]      w_diff, w_d;
  logic [24:0]     w_sum;
  logic            w_sum_sign;
  logic            w_norm_exit;

  // grants are gated by reset so req_ready reads zero while rstn is low
  assign w_arb_en = (r_state == S_IDLE) && rstn;

  fp_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk     (clk),
    .rstn    (rstn),
    .i_req   (req_valid),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_id    (w_gid)
  );

  assign w_accept  = |(req_valid & w_grant);
  assign req_ready = w_grant;
  assign res_valid = (r_state == S_DONE);
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign res_ovf   = r_res_ovf;

  // field split with flush-to-zero and capped exponent difference
  always_comb begin
    w_ma      = (r_a.exp == 8'd0) ? 24'd0 : {1'b1, r_a.frac};
    w_mb      = (r_b.exp == 8'd0) ? 24'd0 : {1'b1, r_b.frac};
    w_sb      = r_b.sign ^ r_sub;
    w_special = (r_a.exp == EXP_MAX) || (r_b.exp == EXP_MAX);
    w_b_big   = (r_b.exp > r_a.exp);
    w_diff    = w_b_big ? (r_b.exp - r_a.exp) : (r_a.exp - r_b.exp);
    w_d       = (w_diff > MAX_D) ? MAX_D : w_diff;
  end

  // signed-magnitude add; equal magnitudes of opposite sign give +0
  always_comb begin
    w_sum      = 25'd0;
    w_sum_sign = 1'b0;
    if (r_sx == r_sy) begin
      w_sum      = {1'b0, r_mx} + {1'b0, r_my};
      w_sum_sign = r_sx;
    end else if (r_mx > r_my) begin
      w_sum      = {1'b0, r_mx} - {1'b0, r_my};
      w_sum_sign = r_sx;
    end else if (r_my > r_mx) begin
      w_sum      = {1'b0, r_my} - {1'b0, r_mx};
      w_sum_sign = r_sy;
    end
  end

  // normalize finishes on carry, zero, a set hidden bit, or exponent hitting zero
  assign w_norm_exit = r_man[24] || (r_man == 25'd0) || r_man[23] || (r_exp == 9'd1);

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_UNPACK;
      // special operands spend a second UNPACK cycle so the flag is registered before PACK
      S_UNPACK: if (w_special) w_state_nxt = r_special ? S_PACK : S_UNPACK;
                else           w_state_nxt = S_ALIGN;
      S_ALIGN:  if (r_cnt == 8'd0) w_state_nxt = S_ADD;
      S_ADD:    w_state_nxt = S_NORM;
      S_NORM:   if (w_norm_exit) w_state_nxt = S_PACK;
      S_PACK:   w_state_nxt = S_DONE;
      S_DONE:   if (res_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // operand capture and per-state datapath updates
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a        <= '0;
      r_b        <= '0;
      r_sub      <= 1'b0;
      r_id       <= '0;
      r_special  <= 1'b0;
      r_sx       <= 1'b0;
      r_sy       <= 1'b0;
      r_sign     <= 1'b0;
      r_mx       <= '0;
      r_my       <= '0;
      r_man      <= '0;
      r_exp      <= '0;
      r_cnt      <= '0;
      r_res_data <= '0;
      r_res_id   <= '0;
      r_res_ovf  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_a       <= req_a[int'(w_gid)*32 +: 32];
          r_b       <= req_b[int'(w_gid)*32 +: 32];
          r_sub     <= req_sub[w_gid];
          r_id      <= w_gid;
          r_special <= 1'b0;
        end
        S_UNPACK: begin
          r_special <= w_special;
          r_sign    <= r_a.sign;
          r_cnt     <= w_d;
          if (w_b_big) begin
            r_mx  <= w_mb;  r_sx <= w_sb;
            r_my  <= w_ma;  r_sy <= r_a.sign;
            r_exp <= {1'b0, r_b.exp};
          end else begin
            r_mx  <= w_ma;  r_sx <= r_a.sign;
            r_my  <= w_mb;  r_sy <= w_sb;
            r_exp <= {1'b0, r_a.exp};
          end
        end
        S_ALIGN: if (r_cnt != 8'd0) begin
          r_my  <= r_my >> 1;
          r_cnt <= r_cnt - 8'd1;
        end
        S_ADD: begin
          r_man  <= w_sum;
          r_sign <= w_sum_sign;
        end
        S_NORM: begin
          if (r_man[24]) begin
            r_man <= r_man >> 1;
            r_exp <= r_exp + 9'd1;
          end else if (r_man == 25'd0) begin
            r_exp <= 9'd0;
          end else if (!r_man[23]) begin
            if (r_exp == 9'd1) begin
              r_man <= 25'd0;
              r_exp <= 9'd0;
            end else begin
              r_man <= r_man << 1;
              r_exp <= r_exp - 9'd1;
            end
          end
        end
        S_PACK: begin
          r_res_id <= r_id;
          if (r_special || (r_exp >= 9'd255)) begin
            r_res_data <= {r_sign, EXP_MAX, 23'd0};
            r_res_ovf  <= 1'b1;
          end else begin
            r_res_data <= {r_sign, r_exp[7:0], r_man[22:0]};
            r_res_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Randomized and directed checks of fp_addsub_sched against an arithmetic reference.
module tb_fp_addsub_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a, req_b;
  logic [1:0]  req_sub;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [0:0]  res_id;
  logic        res_ovf;

  logic [31:0] op_a [2];
  logic [31:0] op_b [2];
  logic        op_sub [2];

  int n_checks = 0;
  int n_fail   = 0;
  int rr_ptr   = 1;
  int last_w, last_lat;
  logic [31:0] last_data;
  logic        last_ovf;

  assign req_a   = {op_a[1], op_a[0]};
  assign req_b   = {op_b[1], op_b[0]};
  assign req_sub = {op_sub[1], op_sub[0]};

  always #5 clk = ~clk;

  fp_addsub_sched #(.NREQ(2), .MAX_ALIGN(25)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ovf   (res_ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: align by d in one step, add, then walk normalization one step per cycle
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                output logic [31:0] r, output logic o, output int lat);
    int ea, eb, e, d, ncyc;
    longint ma, mb, mx, my, m;
    bit sa, sb, sx, sy, s;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || eb == 255) begin
      r = {a[31], 8'hFF, 23'h0};
      o = 1'b1;
      lat = 3;
      return;
    end
    ma = (ea == 0) ? 0 : (longint'(a[22:0]) + (64'd1 << 23));
    mb = (eb == 0) ? 0 : (longint'(b[22:0]) + (64'd1 << 23));
    sa = a[31];
    sb = b[31] ^ sub;
    if (eb > ea) begin
      e = eb; mx = mb; sx = sb; my = ma; sy = sa; d = eb - ea;
    end else begin
      e = ea; mx = ma; sx = sa; my = mb; sy = sb; d = ea - eb;
    end
    if (d > 25) d = 25;
    my = my >> d;
    if (sx == sy) begin m = mx + my; s = sx; end
    else if (mx > my) begin m = mx - my; s = sx; end
    else if (my > mx) begin m = my - mx; s = sy; end
    else begin m = 0; s = 0; end
    ncyc = 1;
    for (int k = 0; k < 40; k++) begin
      if (m >= (64'd1 << 24)) begin m = m >> 1; e = e + 1; break; end
      if (m == 0) begin e = 0; break; end
      if (m >= (64'd1 << 23)) break;
      m = m << 1;
      e = e - 1;
      if (e == 0) begin m = 0; break; end
      ncyc++;
    end
    if (e >= 255) begin
      r = {s, 8'hFF, 23'h0};
      o = 1'b1;
    end else begin
      r = {s, 8'(e), 23'(m)};
      o = 1'b0;
    end
    lat = 4 + d + ncyc;
  endfunction

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
    op_a[i] = a;
    op_b[i] = b;
    op_sub[i] = sub;
  endtask

  // called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_op(input logic [1:0] vmask, input int hold);
    int w, lat, el;
    logic [31:0] er;
    logic eo;
    req_valid = vmask;
    #1;
    w = 0;
    for (int k = 1; k <= 2; k++) begin
      if (vmask[(rr_ptr + k) % 2]) begin
        w = (rr_ptr + k) % 2;
        break;
      end
    end
    chk("grant", 64'(req_ready), 64'(2'b01 << w));
    rr_ptr = w;
    model(op_a[w], op_b[w], op_sub[w], er, eo, el);
    @(negedge clk);
    chk("busy_rdy", 64'(req_ready), 64'd0);
    lat = 0;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(el));
    chk("res_data", 64'(res_data), 64'(er));
    chk("res_id", 64'(res_id), 64'(w));
    chk("res_ovf", 64'(res_ovf), 64'(eo));
    last_w = w; last_lat = lat; last_data = res_data; last_ovf = res_ovf;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'd1);
      chk("hold_data", 64'(res_data), 64'(er));
      chk("hold_id", 64'(res_id), 64'(w));
      chk("hold_rdy", 64'(req_ready), 64'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("released", 64'(res_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rstn = 1'b0;
    req_valid = 2'b00;
    res_ready = 1'b0;
    set_op(0, 32'h0, 32'h0, 1'b0);
    set_op(1, 32'h0, 32'h0, 1'b0);
    #1;
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_data", 64'(res_data), 64'd0);
    chk("rst_id", 64'(res_id), 64'd0);
    chk("rst_ovf", 64'(res_ovf), 64'd0);
    req_valid = 2'b11;
    #1;
    chk("rst_rdy", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // both requesters held valid from reset: grants alternate starting at 0
    set_op(0, 32'h41F00000, 32'h41200000, 1'b0);
    set_op(1, 32'h3F800000, 32'h3F800000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      run_op(2'b11, (k == 0) ? 5 : 1);
      chk("rr_seq", 64'(last_w), 64'(k % 2));
      if (k == 0) begin
        chk("add30_10_data", 64'(last_data), 64'h42200000);
        chk("add30_10_lat", 64'(last_lat), 64'd6);
      end
      if (k == 1) begin
        chk("sub_eq_data", 64'(last_data), 64'h0);
        chk("sub_eq_lat", 64'(last_lat), 64'd5);
      end
    end

    set_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    run_op(2'b01, 0);
    chk("ovf_data", 64'(last_data), 64'h7F800000);
    chk("ovf_flag", 64'(last_ovf), 64'd1);

    set_op(1, 32'h7F800000, 32'h3F800000, 1'b0);
    run_op(2'b10, 0);
    chk("special_lat", 64'(last_lat), 64'd3);
    chk("special_flag", 64'(last_ovf), 64'd1);

    set_op(0, 32'h4B800000, 32'h3F800000, 1'b0);
    run_op(2'b01, 1);
    chk("big_d_data", 64'(last_data), 64'h4B800000);
    chk("big_d_lat", 64'(last_lat), 64'd29);

    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 2; i++) begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 3))
          0: ;
          1: rb[30:23] = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
          2: rb = {ra[31:8], 8'($urandom)};
          default: rb[30:23] = 8'($urandom_range(0, 2));
        endcase
        set_op(i, ra, rb, 1'($urandom));
      end
      run_op(2'($urandom_range(1, 3)), $urandom_range(0, 2));
    end
    req_valid = 2'b00;

    // leave a nonzero result with id 1 and ovf set, then reset during ALIGN
    set_op(1, 32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0);
    run_op(2'b10, 0);
    chk("neg_ovf_data", 64'(last_data), 64'hFF800000);
    set_op(0, 32'h4B800000, 32'h3F800000, 1'b0);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_data", 64'(res_data), 64'd0);
    chk("mid_rst_id", 64'(res_id), 64'd0);
    chk("mid_rst_ovf", 64'(res_ovf), 64'd0);
    chk("mid_rst_rdy", 64'(req_ready), 64'd0);
    @(negedge clk);
    req_valid = 2'b00;
    rstn = 1'b1;
    rr_ptr = 1;
    @(negedge clk);
    chk("post_rst_valid", 64'(res_valid), 64'd0);
    set_op(1, 32'h41F00000, 32'h41200000, 1'b1);
    run_op(2'b11, 0);
    chk("post_rst_rr", 64'(last_w), 64'd0);
    run_op(2'b10, 0);
    chk("post_rst_sub", 64'(last_data), 64'h41A00000);
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
